// File: rtl/alu_pkg.sv
// Shared definitions for the EX/MEM stage: ALU control codes, the multiply
// sequencer state encoding and the iterative multiplier step count.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;

  localparam int MUL_ITERS = 32;
  localparam int MUL_CNT_W = $clog2(MUL_ITERS);
  localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per clock.
// start_i loads the operands; done_o is high during the cycle whose edge
// performs the final step, after which product_o holds the low 32 bits.
module mul_iter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] product_o
);

  logic [31:0]          mcand_q, mcand_d;
  logic [31:0]          mplier_q, mplier_d;
  logic [31:0]          acc_q, acc_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
  logic                 run_q, run_d;

  assign done_o    = run_q && (cnt_q == MUL_LAST);
  assign product_o = acc_q;

  // Operand load on start, otherwise one shift-add step per cycle while running.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done_o) begin
        run_d = 1'b0;
      end
    end
  end

  // Datapath and counter registers, cleared by reset even mid-operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register: operand forwarding, ALU and
// optional multi-cycle multiply.
// Build option EX_MUL_EN: when defined, ALU code 10 runs the iterative
// multiplier under a small sequencer and stalls the front end via ex_busy.
// When undefined, code 10 behaves like any unused code (result 0, 1 cycle).
//
// state   | meaning
// IDLE    | single-cycle ops flow through; a MUL op launches the multiplier
// RUN     | multiplier stepping, bubbles issued, front end held
// DONE    | product written to EX/MEM with the captured destination info
module ex_mem_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_1_in,
  input  logic [31:0] data_2_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] PC_in,
  input  logic [4:0]  Rd_in,
  input  logic [4:0]  rs1_in,
  input  logic [4:0]  rs2_in,
  input  logic [3:0]  ALU_ctrl_in,
  input  logic        ALU_src_in,
  input  logic        auipc_in,
  input  logic        MEM_wen_in,
  input  logic        WB_sel_in,
  input  logic        Reg_WB_in,
  input  logic [31:0] mem_fwd_data,
  input  logic [4:0]  mem_fwd_rd,
  input  logic        mem_fwd_wen,
  input  logic [31:0] wb_fwd_data,
  input  logic [4:0]  wb_fwd_rd,
  input  logic        wb_fwd_wen,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [4:0]  Rd_out,
  output logic        MEM_wen_out,
  output logic        WB_sel_out,
  output logic        Reg_WB_out,
  output logic        ex_busy
);

  logic [31:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_res;
  logic [31:0] alu_result_d, store_data_d;
  logic [4:0]  rd_d;
  logic        mem_wen_d, wb_sel_d, reg_wb_d;

  // Forwarding: the younger EX/MEM value wins over WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = data_1_in;
    if (mem_fwd_wen && (mem_fwd_rd == rs1_in) && (rs1_in != 5'd0)) begin
      fwd_rs1 = mem_fwd_data;
    end else if (wb_fwd_wen && (wb_fwd_rd == rs1_in) && (rs1_in != 5'd0)) begin
      fwd_rs1 = wb_fwd_data;
    end
    fwd_rs2 = data_2_in;
    if (mem_fwd_wen && (mem_fwd_rd == rs2_in) && (rs2_in != 5'd0)) begin
      fwd_rs2 = mem_fwd_data;
    end else if (wb_fwd_wen && (wb_fwd_rd == rs2_in) && (rs2_in != 5'd0)) begin
      fwd_rs2 = wb_fwd_data;
    end
  end

  // Operand selection and single-cycle ALU; MUL and unused codes give 0 here.
  always_comb begin
    op_a = auipc_in   ? PC_in  : fwd_rs1;
    op_b = ALU_src_in ? imm_in : fwd_rs2;
    case (ALU_ctrl_in)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLL:  alu_res = op_a << op_b[4:0];
      ALU_SRL:  alu_res = op_a >> op_b[4:0];
      ALU_SRA:  alu_res = $signed(op_a) >>> op_b[4:0];
      ALU_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'b0, op_a < op_b};
      default:  alu_res = '0;
    endcase
  end

`ifdef EX_MUL_EN
  ex_state_e   state_q, state_d;
  logic [4:0]  mul_rd_q;
  logic        mul_reg_wb_q, mul_wb_sel_q;
  logic        mul_start, mul_done;
  logic [31:0] mul_product;

  mul_iter u_mul_iter (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start),
    .a_i       (op_a),
    .b_i       (op_b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Sequencer next state, stall request and EX/MEM register input selection.
  always_comb begin
    state_d      = state_q;
    mul_start    = 1'b0;
    ex_busy      = 1'b0;
    alu_result_d = alu_res;
    store_data_d = fwd_rs2;
    rd_d         = Rd_in;
    mem_wen_d    = MEM_wen_in;
    wb_sel_d     = WB_sel_in;
    reg_wb_d     = Reg_WB_in;
    case (state_q)
      ST_IDLE: begin
        if (ALU_ctrl_in == ALU_MUL) begin
          mul_start = 1'b1;
          ex_busy   = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        ex_busy = 1'b1;
        if (mul_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_q == ST_DONE) begin
      alu_result_d = mul_product;
      store_data_d = '0;
      rd_d         = mul_rd_q;
      mem_wen_d    = 1'b0;
      wb_sel_d     = mul_wb_sel_q;
      reg_wb_d     = mul_reg_wb_q;
    end else if (state_q != ST_IDLE || mul_start) begin
      alu_result_d = '0;
      store_data_d = '0;
      rd_d         = '0;
      mem_wen_d    = 1'b0;
      wb_sel_d     = 1'b0;
      reg_wb_d     = 1'b0;
    end
    if (reset) begin
      ex_busy = 1'b0;
    end
  end

  // Sequencer state and the destination info held for the product writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mul_rd_q     <= '0;
      mul_reg_wb_q <= 1'b0;
      mul_wb_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mul_start) begin
        mul_rd_q     <= Rd_in;
        mul_reg_wb_q <= Reg_WB_in;
        mul_wb_sel_q <= WB_sel_in;
      end
    end
  end
`else
  assign ex_busy = 1'b0;

  // Without the multiplier every op takes the single-cycle path.
  always_comb begin
    alu_result_d = alu_res;
    store_data_d = fwd_rs2;
    rd_d         = Rd_in;
    mem_wen_d    = MEM_wen_in;
    wb_sel_d     = WB_sel_in;
    reg_wb_d     = Reg_WB_in;
  end
`endif

  // EX/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_out <= '0;
      store_data_out <= '0;
      Rd_out         <= '0;
      MEM_wen_out    <= 1'b0;
      WB_sel_out     <= 1'b0;
      Reg_WB_out     <= 1'b0;
    end else begin
      alu_result_out <= alu_result_d;
      store_data_out <= store_data_d;
      Rd_out         <= rd_d;
      MEM_wen_out    <= mem_wen_d;
      WB_sel_out     <= wb_sel_d;
      Reg_WB_out     <= reg_wb_d;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed cases followed by random
// single-cycle traffic, plus multiply and reset-abort cases when EX_MUL_EN is set.
module tb_ex_mem_stage;

`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_1_in, data_2_in, imm_in, PC_in;
  logic [4:0]  Rd_in, rs1_in, rs2_in;
  logic [3:0]  ALU_ctrl_in;
  logic        ALU_src_in, auipc_in, MEM_wen_in, WB_sel_in, Reg_WB_in;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic        mem_fwd_wen, wb_fwd_wen;
  logic [31:0] alu_result_out, store_data_out;
  logic [4:0]  Rd_out;
  logic        MEM_wen_out, WB_sel_out, Reg_WB_out, ex_busy;

  int compared   = 0;
  int mismatched = 0;

  ex_mem_stage dut (
    .clk(clk), .reset(reset),
    .data_1_in(data_1_in), .data_2_in(data_2_in), .imm_in(imm_in), .PC_in(PC_in),
    .Rd_in(Rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .ALU_ctrl_in(ALU_ctrl_in),
    .ALU_src_in(ALU_src_in), .auipc_in(auipc_in), .MEM_wen_in(MEM_wen_in),
    .WB_sel_in(WB_sel_in), .Reg_WB_in(Reg_WB_in),
    .mem_fwd_data(mem_fwd_data), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_wen(mem_fwd_wen),
    .wb_fwd_data(wb_fwd_data), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_wen(wb_fwd_wen),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .Rd_out(Rd_out),
    .MEM_wen_out(MEM_wen_out), .WB_sel_out(WB_sel_out), .Reg_WB_out(Reg_WB_out),
    .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference ALU written from the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input bit mul_en);
    int unsigned       sh;
    longint unsigned   p;
    logic [31:0]       r;
    sh = b % 32;
    case (c)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7:  r = a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd8:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: begin
        p = longint'(a) * longint'(b);
        r = mul_en ? p[31:0] : 32'd0;
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return rf;
    if (mem_fwd_wen && mem_fwd_rd == rs) return mem_fwd_data;
    if (wb_fwd_wen && wb_fwd_rd == rs) return wb_fwd_data;
    return rf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] res, input logic [31:0] st,
                            input logic [4:0] rd, input logic mw, input logic ws, input logic rw);
    chk({tag, "_result"}, alu_result_out, res);
    chk({tag, "_store"}, store_data_out, st);
    chk({tag, "_rd"}, {27'b0, Rd_out}, {27'b0, rd});
    chk({tag, "_memwen"}, {31'b0, MEM_wen_out}, {31'b0, mw});
    chk({tag, "_wbsel"}, {31'b0, WB_sel_out}, {31'b0, ws});
    chk({tag, "_regwb"}, {31'b0, Reg_WB_out}, {31'b0, rw});
  endtask

  task automatic clear_fwd();
    mem_fwd_data = '0; mem_fwd_rd = '0; mem_fwd_wen = 1'b0;
    wb_fwd_data  = '0; wb_fwd_rd  = '0; wb_fwd_wen  = 1'b0;
  endtask

  task automatic set_op(input logic [3:0] c, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic src,
                        input logic au, input logic mw, input logic ws, input logic rw);
    ALU_ctrl_in = c; data_1_in = d1; data_2_in = d2; imm_in = imm; PC_in = pc;
    Rd_in = rd; rs1_in = r1; rs2_in = r2; ALU_src_in = src; auipc_in = au;
    MEM_wen_in = mw; WB_sel_in = ws; Reg_WB_in = rw;
  endtask

  // One single-cycle op: inputs are already driven; result expected after the next edge.
  task automatic cycle_normal(input string tag);
    logic [31:0] f2, a, b, res;
    logic [4:0]  rd;
    logic        mw, ws, rw;
    f2  = ref_fwd(rs2_in, data_2_in);
    a   = auipc_in ? PC_in : ref_fwd(rs1_in, data_1_in);
    b   = ALU_src_in ? imm_in : f2;
    res = ref_alu(ALU_ctrl_in, a, b, MUL_EN);
    rd = Rd_in; mw = MEM_wen_in; ws = WB_sel_in; rw = Reg_WB_in;
    @(negedge clk);
    chk({tag, "_busy"}, {31'b0, ex_busy}, 32'd0);
    @(posedge clk); #1;
    check_outs(tag, res, f2, rd, mw, ws, rw);
  endtask

`ifdef EX_MUL_EN
  // MUL launched in the current cycle N; operands via data_1 and imm.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic ws);
    logic [31:0] exp_p;
    clear_fwd();
    set_op(4'd10, a, $urandom, b, $urandom, rd, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, ws, 1'b1);
    exp_p = ref_alu(4'd10, a, b, 1'b1);
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      chk({tag, "_busy_hi"}, {31'b0, ex_busy}, 32'd1);
      @(posedge clk); #1;
      check_outs({tag, "_bubble"}, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      data_1_in = $urandom; imm_in = $urandom; Rd_in = 5'($urandom);
      MEM_wen_in = 1'b1; WB_sel_in = ~ws; Reg_WB_in = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_busy_done"}, {31'b0, ex_busy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_product"}, alu_result_out, exp_p);
    chk({tag, "_rd"}, {27'b0, Rd_out}, {27'b0, rd});
    chk({tag, "_memwen"}, {31'b0, MEM_wen_out}, 32'd0);
    chk({tag, "_wbsel"}, {31'b0, WB_sel_out}, {31'b0, ws});
    chk({tag, "_regwb"}, {31'b0, Reg_WB_out}, 32'd1);
  endtask
`endif

  initial begin
    reset = 1'b1;
    clear_fwd();
    set_op(4'd10, 32'd9, 32'd9, 32'd9, 32'd0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_busy", {31'b0, ex_busy}, 32'd0);
    @(posedge clk); #1;
    check_outs("reset_outs", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    set_op(4'd0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle_normal("add_basic");
    chk("add_basic_val", alu_result_out, 32'd12);

    mem_fwd_rd = 5'd4; mem_fwd_wen = 1'b1; mem_fwd_data = 32'd100;
    wb_fwd_rd  = 5'd4; wb_fwd_wen  = 1'b1; wb_fwd_data  = 32'd200;
    set_op(4'd0, 32'd55, 32'd0, 32'd1, 32'd0, 5'd6, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle_normal("fwd_mem_wins");
    chk("fwd_mem_wins_val", alu_result_out, 32'd101);
    mem_fwd_wen = 1'b0;
    cycle_normal("fwd_wb");
    chk("fwd_wb_val", alu_result_out, 32'd201);
    mem_fwd_wen = 1'b1;
    rs1_in = 5'd0; mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
    cycle_normal("fwd_rd0");
    chk("fwd_rd0_val", alu_result_out, 32'd56);
    clear_fwd();

    set_op(4'd0, 32'd0, 32'd0, 32'h2000, 32'h1000, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle_normal("auipc_rd0");
    chk("auipc_val", alu_result_out, 32'h3000);

    set_op(4'd7, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle_normal("sra");
    chk("sra_val", alu_result_out, 32'hF800_0000);
    set_op(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd9, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle_normal("slt");
    chk("slt_val", alu_result_out, 32'd1);
    ALU_ctrl_in = 4'd9;
    cycle_normal("sltu");
    chk("sltu_val", alu_result_out, 32'd0);
    ALU_ctrl_in = 4'd13;
    cycle_normal("unused_code");

    for (int i = 0; i < 300; i++) begin
      logic [3:0] c;
      c = 4'($urandom_range(0, 15));
      if (MUL_EN && c == 4'd10) c = 4'd0;
      set_op(c, $urandom, $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
             $urandom, 5'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      mem_fwd_data = $urandom; mem_fwd_rd = 5'($urandom_range(0, 3)); mem_fwd_wen = 1'($urandom);
      wb_fwd_data  = $urandom; wb_fwd_rd  = 5'($urandom_range(0, 3)); wb_fwd_wen  = 1'($urandom);
      cycle_normal("rand");
    end
    clear_fwd();

`ifdef EX_MUL_EN
    run_mul("mul_ref", 32'hFFFF_FFFF, 32'd3, 5'd7, 1'b0);
    chk("mul_ref_val", alu_result_out, 32'hFFFF_FFFD);
    for (int i = 0; i < 3; i++) begin
      run_mul("mul_rand", $urandom, $urandom, 5'($urandom), 1'($urandom));
    end
    set_op(4'd0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle_normal("after_mul_add");

    set_op(4'd10, 32'd12345, 32'd0, 32'd678, 32'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'b0, ex_busy}, 32'd0);
    @(posedge clk); #1;
    check_outs("abort_outs", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    set_op(4'd0, 32'd20, 32'd22, 32'd0, 32'd0, 5'd11, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle_normal("abort_then_add");
    chk("abort_then_add_val", alu_result_out, 32'd42);
`else
    set_op(4'd10, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle_normal("mul_disabled");
    chk("mul_disabled_val", alu_result_out, 32'd0);

    set_op(4'd0, 32'd20, 32'd22, 32'd0, 32'd0, 5'd11, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset2_busy", {31'b0, ex_busy}, 32'd0);
    @(posedge clk); #1;
    check_outs("reset2_outs", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cycle_normal("reset2_then_add");
    chk("reset2_then_add_val", alu_result_out, 32'd42);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports from ID/EX: data_1_in, data_2_in, imm_in, PC_in  in  32 each; Rd_in, rs1_in, rs2_in  in  5 each; ALU_ctrl_in  in  4; ALU_src_in, auipc_in, MEM_wen_in, WB_sel_in, Reg_WB_in  in  1 each.
REQ-004 SHALL have forwarding ports: mem_fwd_data  in  32, mem_fwd_rd  in  5, mem_fwd_wen  in  1 (EX/MEM stage); wb_fwd_data  in  32, wb_fwd_rd  in  5, wb_fwd_wen  in  1 (WB stage).
REQ-005 SHALL have registered outputs: alu_result_out, store_data_out  out  32; Rd_out  out  5; MEM_wen_out, WB_sel_out, Reg_WB_out  out  1.
REQ-006 SHALL have ex_busy  out  1, combinational; drives PC hold, IF/ID hold and ID/EX stall.

Function
REQ-007 SHALL forward rs1/rs2: EX/MEM source when mem_fwd_wen and mem_fwd_rd==rsX and rsX!=0; else WB source under the same rule; else data_1_in/data_2_in; EX/MEM wins when both match.
REQ-008 SHALL select operand A = PC_in when auipc_in, else forwarded rs1; operand B = imm_in when ALU_src_in, else forwarded rs2.
REQ-009 SHALL decode ALU_ctrl_in: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL; codes 11-15 yield result 0.
REQ-010 SHALL use shift amount B[4:0] for shifts; all arithmetic modulo 2^32; MUL returns low 32 bits of the product.
REQ-011 SHALL register, at each edge in state IDLE for non-MUL ops, result -> alu_result_out, forwarded rs2 -> store_data_out, and Rd/MEM_wen/WB_sel/Reg_WB pass-through (latency 1 cycle).
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE for MUL.
REQ-013 IDLE with ALU_ctrl_in==10 in cycle N: ex_busy=1 combinationally; at edge, capture A, B, Rd_in, Reg_WB_in, WB_sel_in; counter=0; go RUN; EX/MEM outputs load bubble.
REQ-014 RUN: one shift-add iteration per edge; ex_busy=1; EX/MEM outputs load bubble; inputs ignored; after iteration 32 (counter 31) go DONE.
REQ-015 DONE: ex_busy=0; at edge, EX/MEM outputs load product with captured Rd/Reg_WB/WB_sel, MEM_wen_out=0; go IDLE.
REQ-016 SHALL present MUL result on outputs from cycle N+34; ex_busy high for exactly cycles N..N+32.
REQ-017 Bubble SHALL be: all outputs 0 (Reg_WB_out=0, MEM_wen_out=0).
REQ-018 SHALL never forward from rd 0; Rd_out=0 with Reg_WB_out=1 SHALL still pass through.

Reset
REQ-019 reset SHALL zero all outputs, force IDLE, clear counter and captured MUL state, including mid-MUL; reset dominates all other inputs.
REQ-020 ex_busy SHALL be 0 during any cycle reset is high.

Configuration
REQ-021 With EX_MUL_EN defined: FSM and iterative multiplier present per REQ-012..016.
REQ-022 Without EX_MUL_EN: code 10 yields result 0 with single-cycle latency; ex_busy tied 0; no FSM/multiplier logic.

Structure
REQ-023 Shared package alu_pkg SHALL hold ALU_ctrl code constants, the FSM state encoding and the MUL iteration count (32).
REQ-024 Sub-module mul_iter (start, A, B -> done, product) SHALL contain the shift-add datapath and counter; instantiated only under EX_MUL_EN.

Verification
REQ-025 ADD data_1=5, data_2=7, ALU_src=0, Rd=3, Reg_WB=1 -> next cycle alu_result_out=12, Rd_out=3, Reg_WB_out=1.
REQ-026 rs1=4, mem_fwd_rd=4/wen=1/data=100, wb_fwd_rd=4/wen=1/data=200, ADD imm 1 -> alu_result_out=101; same with rs1=0 -> data_1_in+1.
REQ-027 auipc=1, PC=0x1000, imm=0x2000, ALU_src=1, ADD -> alu_result_out=0x3000.
REQ-028 SRA A=0x80000000, B=4 -> 0xF8000000; SLT A=-1, B=1 -> 1; SLTU same -> 0.
REQ-029 EX_MUL_EN, MUL A=0xFFFFFFFF, B=3 at cycle N -> ex_busy high N..N+32, bubbles until N+33, alu_result_out=0xFFFFFFFD from N+34.
REQ-030 reset asserted at N+10 of a MUL -> next cycle all outputs 0, ex_busy=0; fresh ADD after reset completes in 1 cycle.
